demux1x8_deser: RTL and testbench

Serial-to-parallel receiver paired with the team's 8:1 bit-select mux. The mux drives `in[s]` onto a single line as `s` walks 0..7. This block is the far end of that line: it demultiplexes each serial bit into bit position `sel` of an 8-bit word, then presents the completed word on a valid/ready output. Double buffering lets a new frame be collected while the previous word waits for the consumer.

---
 rtl/demux1x8_deser.sv | 133 +++++++++++++
 tb/tb_demux1x8_deser.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/demux1x8_deser.sv
// demux1x8_deser: serial-to-parallel receiver for the 8:1 bit-select mux line.
// Each sampled bit is steered into one lane of an 8-bit assembly register; the
// completed word moves to a valid/ready output register so the next frame can
// be collected while the previous word waits for the consumer.

// One assembly-register lane: takes the incoming bit when this lane is the
// destination of the current write, otherwise keeps its stored value.
module demux1x8_deser_lane #(
  parameter int LANE      = 0,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [2:0] idx,
  input  logic       we,
  input  logic       d,
  input  logic       cur,
  output logic       nxt
);
  // Frame bit k lands in lane k, or in lane 7-k for MSB-first framing.
  localparam logic [2:0] POS = MSB_FIRST ? 3'(7 - LANE) : 3'(LANE);

  // Lane update mux.
  always_comb begin
    nxt = cur;
    if (we && (idx == POS)) nxt = d;
  end
endmodule

module demux1x8_deser #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  input  logic       sin_valid,
  input  logic       sof,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [2:0] sel,
  output logic       busy,
  output logic       overrun
);
  localparam int NUM_LANES = 8;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                 state, state_n;
  logic [2:0]             sel_n;
  logic [NUM_LANES-1:0]   asm_q, asm_n;
  logic                   bit_we;
  logic [2:0]             bit_idx;
  logic                   done;
  logic [7:0]             dout_n;
  logic                   dv_n;
  logic                   ov_n;

  // asm_n is also the completed word: it already has the final bit merged in.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    demux1x8_deser_lane #(.LANE(l), .MSB_FIRST(MSB_FIRST)) u_lane (
      .idx (bit_idx),
      .we  (bit_we),
      .d   (sin),
      .cur (asm_q[l]),
      .nxt (asm_n[l])
    );
  end

  // Frame sequencing: sof always restarts at bit 0 (even at position 7),
  // non-sof bits are only taken mid-frame, bit 7 without sof completes.
  always_comb begin
    state_n = state;
    sel_n   = sel;
    bit_we  = 1'b0;
    bit_idx = sel;
    done    = 1'b0;
    if (sin_valid) begin
      if (sof) begin
        bit_we  = 1'b1;
        bit_idx = 3'd0;
        sel_n   = 3'd1;
        state_n = COLLECT;
      end else if (state == COLLECT) begin
        bit_we = 1'b1;
        if (sel == 3'd7) begin
          done    = 1'b1;
          sel_n   = 3'd0;
          state_n = IDLE;
        end else begin
          sel_n = sel + 3'd1;
        end
      end
    end
  end

  // Output buffer: load on completion if the slot is free or being drained on
  // this edge; otherwise drop the new word and flag overrun.
  always_comb begin
    dout_n = dout;
    dv_n   = dout_valid;
    ov_n   = 1'b0;
    if (done) begin
      if (!dout_valid || dout_ready) begin
        dout_n = asm_n;
        dv_n   = 1'b1;
      end else begin
        ov_n = 1'b1;
      end
    end else if (dout_valid && dout_ready) begin
      dv_n = 1'b0;
    end
  end

  // State, assembly and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 3'd0;
      asm_q      <= '0;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      asm_q      <= asm_n;
      dout       <= dout_n;
      dout_valid <= dv_n;
      overrun    <= ov_n;
    end
  end

  assign busy = (state == COLLECT);
endmodule

// File: tb/tb_demux1x8_deser.sv
// Bench for demux1x8_deser: LSB-first and MSB-first instances share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_demux1x8_deser;
  logic       clk, rst_n, sin, sin_valid, sof, dout_ready;
  logic [7:0] dout0, dout1;
  logic       dv0, dv1, busy0, busy1, ov0, ov1;
  logic [2:0] sel0, sel1;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: bits of the frame in progress, and the output buffer.
  bit         q[$];
  logic [7:0] m_dout0, m_dout1;
  logic       m_dv, m_ov;

  demux1x8_deser #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .dout(dout0), .dout_valid(dv0), .dout_ready(dout_ready),
    .sel(sel0), .busy(busy0), .overrun(ov0));

  demux1x8_deser #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .dout(dout1), .dout_valid(dv1), .dout_ready(dout_ready),
    .sel(sel1), .busy(busy1), .overrun(ov1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_dout0 = 8'h00; m_dout1 = 8'h00; m_dv = 1'b0; m_ov = 1'b0;
  endtask

  // One clock edge of the model, from the frame rules.
  task automatic model_step(input bit v, input bit s, input bit f, input bit r);
    bit         cmp = 0;
    logic [7:0] w0 = 8'h00, w1 = 8'h00;
    if (v) begin
      if (f) begin
        q.delete();
        q.push_back(s);
      end else if (q.size() > 0) begin
        q.push_back(s);
        if (q.size() == 8) begin
          cmp = 1;
          for (int k = 0; k < 8; k++) begin
            w0[k]     = q[k];
            w1[7 - k] = q[k];
          end
          q.delete();
        end
      end
    end
    m_ov = 1'b0;
    if (cmp) begin
      if (!m_dv || r) begin
        m_dout0 = w0; m_dout1 = w1; m_dv = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
    end else if (m_dv && r) begin
      m_dv = 1'b0;
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":dout0"}, dout0, m_dout0);
    chk({ph, ":dout1"}, dout1, m_dout1);
    chk({ph, ":dv0"}, {7'd0, dv0}, {7'd0, m_dv});
    chk({ph, ":dv1"}, {7'd0, dv1}, {7'd0, m_dv});
    chk({ph, ":sel0"}, {5'd0, sel0}, 8'(q.size()));
    chk({ph, ":sel1"}, {5'd0, sel1}, 8'(q.size()));
    chk({ph, ":busy"}, {6'd0, busy1, busy0}, {6'd0, {2{q.size() != 0}}});
    chk({ph, ":ovr"}, {6'd0, ov1, ov0}, {6'd0, {2{m_ov}}});
  endtask

  // Drive one cycle of inputs, advance the model with them, check after edge.
  task automatic cycle(input string ph, input bit v, input bit s, input bit f, input bit r);
    sin_valid = v; sin = s; sof = f; dout_ready = r;
    @(posedge clk);
    model_step(v, s, f, r);
    #1;
    check_all(ph);
  endtask

  // Send a frame LSB-first on the line, with optional random idle gaps.
  task automatic send(input string ph, input logic [7:0] w, input bit gaps,
                      input bit rdy, input bit rdy_last);
    for (int k = 0; k < 8; k++) begin
      while (gaps && ($urandom_range(0, 2) == 0))
        cycle(ph, 1'b0, 1'($urandom), 1'($urandom), rdy);
      cycle(ph, 1'b1, w[k], k == 0, (k == 7) ? rdy_last : rdy);
    end
  endtask

  task automatic async_reset(input string ph);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all(ph);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; sin = 0; sin_valid = 0; sof = 0; dout_ready = 0;
    model_reset();
    #3 check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // Basic frame
    send("basic", 8'h14, 1'b0, 1'b1, 1'b1);
    chk("basic:word", dout0, 8'h14);
    chk("basic:valid", {7'd0, dv0}, 8'd1);
    cycle("basic_drain", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("basic:cleared", {7'd0, dv0}, 8'd0);

    // Back-to-back with gaps
    send("b2b", 8'h97, 1'b1, 1'b1, 1'b1);
    chk("b2b:w1", dout0, 8'h97);
    send("b2b", 8'h2E, 1'b1, 1'b1, 1'b1);
    chk("b2b:w2", dout0, 8'h2E);

    // Overrun
    cycle("idle", 1'b0, 1'b0, 1'b0, 1'b1);
    send("ovr", 8'h14, 1'b0, 1'b0, 1'b0);
    send("ovr", 8'h97, 1'b0, 1'b0, 1'b0);
    chk("ovr:pulse", {7'd0, ov0}, 8'd1);
    chk("ovr:held", dout0, 8'h14);
    cycle("ovr_after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr:one_cycle", {7'd0, ov0}, 8'd0);
    cycle("ovr_drain", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr:cleared", {7'd0, dv0}, 8'd0);

    // Simultaneous accept and complete
    send("sim", 8'h14, 1'b0, 1'b0, 1'b0);
    send("sim", 8'h2E, 1'b0, 1'b0, 1'b1);
    chk("sim:word", dout0, 8'h2E);
    chk("sim:valid", {7'd0, dv0}, 8'd1);
    chk("sim:no_ovr", {7'd0, ov0}, 8'd0);
    cycle("sim_drain", 1'b0, 1'b0, 1'b0, 1'b1);

    // Resync: 5 bits then a fresh frame
    for (int k = 0; k < 5; k++) cycle("resync", 1'b1, 1'($urandom), k == 0, 1'b1);
    send("resync", 8'h97, 1'b0, 1'b1, 1'b1);
    chk("resync:lsb", dout0, 8'h97);
    chk("resync:msb", dout1, 8'hE9);

    // sof on the 8th position restarts instead of completing
    for (int k = 0; k < 7; k++) cycle("sof7", 1'b1, 1'($urandom), k == 0, 1'b1);
    cycle("sof7", 1'b1, 1'b1, 1'b1, 1'b1);
    chk("sof7:sel", {5'd0, sel0}, 8'd1);

    // Reset mid-frame, then non-sof bits must be ignored
    async_reset("rst_pre");
    for (int k = 0; k < 4; k++) cycle("mid", 1'b1, 1'($urandom), k == 0, 1'b0);
    async_reset("rst_mid");
    chk("rst_mid:sel", {5'd0, sel0}, 8'd0);
    for (int k = 0; k < 10; k++) cycle("post_rst", 1'b1, 1'($urandom), 1'b0, 1'b0);
    chk("post_rst:busy", {7'd0, busy0}, 8'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cycle("rand", ($urandom_range(0, 3) != 0), 1'($urandom),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) != 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
